// File: rtl/ets_vernier_sequencer.sv
// Vernier index sequencer: steps MMCM phase, settles, grants capture beats per point of T_MIN..T_MAX.
// Latency: start -> ps_en next cycle; ps_done -> t_valid after settle+1 cycles; last beat -> next ps_en/sweep_done next cycle.
// Backpressure: t_valid held with T stable until captures_per_pt beats accepted via t_ready.
// Optional macro ETS_SEQ_PS_TIMEOUT_EN adds a 16-bit phase-shift watchdog driving the sticky err flag.

module ets_vernier_sequencer #(
   parameter int T_MIN    = 2,
   parameter int T_MAX    = 120,
   parameter int SETTLE_W = 16,
   parameter int CNT_W    = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                continuous,
   input  logic [SETTLE_W-1:0] settle_cycles,
   input  logic [CNT_W-1:0]    captures_per_pt,
   output logic                ps_en,
   input  logic                ps_done,
   output logic [7:0]          T,
   output logic                t_valid,
   input  logic                t_ready,
   output logic                busy,
   output logic                sweep_done,
   output logic                err
);

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_SHIFT   = 3'd1;
   localparam logic [2:0] ST_WAIT_PS = 3'd2;
   localparam logic [2:0] ST_SETTLE  = 3'd3;
   localparam logic [2:0] ST_CAPTURE = 3'd4;
   localparam logic [2:0] ST_DONE    = 3'd5;

   localparam logic [6:0] T_MIN_L = 7'(T_MIN);
   localparam logic [6:0] T_MAX_L = 7'(T_MAX);

   logic [2:0]          state_q, state_d;
   logic [7:0]          t_q, t_d;
   logic                ps_en_q, ps_en_d;
   logic                t_valid_q, t_valid_d;
   logic                busy_q, busy_d;
   logic                sweep_done_q, sweep_done_d;
   logic [SETTLE_W-1:0] settle_lat_q, settle_lat_d;
   logic [SETTLE_W-1:0] settle_cnt_q, settle_cnt_d;
   logic [CNT_W-1:0]    cap_lat_q, cap_lat_d;
   logic [CNT_W-1:0]    cap_cnt_q, cap_cnt_d;

`ifdef ETS_SEQ_PS_TIMEOUT_EN
   logic [15:0]         wd_cnt_q, wd_cnt_d;
   logic                err_q, err_d;
`endif

   // Next-state, counter and index computation; outputs are registered copies of the next state.
   always_comb begin
      state_d      = state_q;
      t_d          = t_q;
      settle_lat_d = settle_lat_q;
      settle_cnt_d = settle_cnt_q;
      cap_lat_d    = cap_lat_q;
      cap_cnt_d    = cap_cnt_q;
`ifdef ETS_SEQ_PS_TIMEOUT_EN
      wd_cnt_d     = wd_cnt_q;
      err_d        = err_q;
`endif

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               settle_lat_d = settle_cycles;
               // A zero beat count would never complete a point, so it is treated as one beat.
               cap_lat_d    = (captures_per_pt == '0) ? CNT_W'(1) : captures_per_pt;
               t_d          = {1'b1, T_MIN_L};
               state_d      = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            settle_cnt_d = '0;
            cap_cnt_d    = '0;
`ifdef ETS_SEQ_PS_TIMEOUT_EN
            wd_cnt_d     = '0;
`endif
            state_d      = ST_WAIT_PS;
         end
         ST_WAIT_PS: begin
            if (ps_done) begin
               state_d = (settle_lat_q != '0) ? ST_SETTLE : ST_CAPTURE;
            end
`ifdef ETS_SEQ_PS_TIMEOUT_EN
            else if (wd_cnt_q == 16'hFFFF) begin
               // The MMCM never answered: abandon the sweep and flag it until reset.
               err_d   = 1'b1;
               state_d = ST_IDLE;
            end else begin
               wd_cnt_d = wd_cnt_q + 16'd1;
            end
`endif
         end
         ST_SETTLE: begin
            if (settle_cnt_q == settle_lat_q - SETTLE_W'(1)) begin
               state_d = ST_CAPTURE;
            end else begin
               settle_cnt_d = settle_cnt_q + SETTLE_W'(1);
            end
         end
         ST_CAPTURE: begin
            if (t_valid_q && t_ready) begin
               if (cap_cnt_q == cap_lat_q - CNT_W'(1)) begin
                  if (t_q[6:0] != T_MAX_L) begin
                     t_d     = {1'b0, t_q[6:0] + 7'd1};
                     state_d = ST_SHIFT;
                  end else begin
                     state_d = ST_DONE;
                  end
               end else begin
                  cap_cnt_d = cap_cnt_q + CNT_W'(1);
               end
            end
         end
         ST_DONE: begin
            if (continuous) begin
               t_d     = {1'b1, T_MIN_L};
               state_d = ST_SHIFT;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      ps_en_d      = (state_d == ST_SHIFT);
      t_valid_d    = (state_d == ST_CAPTURE);
      busy_d       = (state_d != ST_IDLE);
      sweep_done_d = (state_d == ST_DONE);
   end

   // State, latched configuration, counters and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         t_q          <= 8'd0;
         ps_en_q      <= 1'b0;
         t_valid_q    <= 1'b0;
         busy_q       <= 1'b0;
         sweep_done_q <= 1'b0;
         settle_lat_q <= '0;
         settle_cnt_q <= '0;
         cap_lat_q    <= '0;
         cap_cnt_q    <= '0;
      end else begin
         state_q      <= state_d;
         t_q          <= t_d;
         ps_en_q      <= ps_en_d;
         t_valid_q    <= t_valid_d;
         busy_q       <= busy_d;
         sweep_done_q <= sweep_done_d;
         settle_lat_q <= settle_lat_d;
         settle_cnt_q <= settle_cnt_d;
         cap_lat_q    <= cap_lat_d;
         cap_cnt_q    <= cap_cnt_d;
      end
   end

`ifdef ETS_SEQ_PS_TIMEOUT_EN
   // Phase-shift watchdog counter and sticky error flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wd_cnt_q <= '0;
         err_q    <= 1'b0;
      end else begin
         wd_cnt_q <= wd_cnt_d;
         err_q    <= err_d;
      end
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   assign ps_en      = ps_en_q;
   assign T          = t_q;
   assign t_valid    = t_valid_q;
   assign busy       = busy_q;
   assign sweep_done = sweep_done_q;

endmodule

// File: tb/tb_ets_vernier_sequencer.sv
// Directed bench for ets_vernier_sequencer with a small MMCM responder and a protocol monitor.
// Sweeps T_MIN=2..T_MAX=4 and checks index order, beat counts, latencies, wrap, reset and watchdog.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled on the falling edge.

module tb_ets_vernier_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        continuous;
   logic [15:0] settle_cycles;
   logic [15:0] captures_per_pt;
   logic        ps_en;
   logic        ps_done;
   logic [7:0]  T;
   logic        t_valid;
   logic        t_ready;
   logic        busy;
   logic        sweep_done;
   logic        err;

   ets_vernier_sequencer #(
      .T_MIN   (2),
      .T_MAX   (4),
      .SETTLE_W(16),
      .CNT_W   (16)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .continuous     (continuous),
      .settle_cycles  (settle_cycles),
      .captures_per_pt(captures_per_pt),
      .ps_en          (ps_en),
      .ps_done        (ps_done),
      .T              (T),
      .t_valid        (t_valid),
      .t_ready        (t_ready),
      .busy           (busy),
      .sweep_done     (sweep_done),
      .err            (err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_errors++;
         $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp_v);
      end
   endtask

   // Stimulus knobs
   int ps_delay = 5;
   bit ps_hold  = 1'b0;
   int tr_mode  = 0;     // 0: always ready, 1: toggle each cycle, 2: never ready
   int exp_lat  = 1;     // expected cycles from ps_done sample to first t_valid
   int exp_caps = 1;     // expected beats per point

   // Monitor statistics
   int         ps_en_cnt, beat_cnt, done_cnt;
   int         lat_err, pulse_err, beat_err, stab_err;
   int         pd_cyc, pt_beats;
   logic [7:0] cur_t;
   logic [7:0] t_log[$];
   bit         ps_en_prev, tv_prev;

   task automatic reset_stats();
      ps_en_cnt = 0; beat_cnt = 0; done_cnt = 0;
      lat_err = 0; pulse_err = 0; beat_err = 0; stab_err = 0;
      pt_beats = 0;
      t_log.delete();
   endtask

   function automatic logic [7:0] tlog_at(input int i);
      if (i < t_log.size()) return t_log[i];
      return 8'hxx;
   endfunction

   // MMCM model: answers each ps_en with a one-cycle ps_done after ps_delay cycles.
   initial begin
      ps_done = 1'b0;
      forever begin
         @(posedge clk); #1;
         if (ps_en && !rst) begin
            repeat (ps_delay) @(posedge clk);
            #1;
            if (!ps_hold && !rst) ps_done = 1'b1;
            @(posedge clk); #1;
            ps_done = 1'b0;
         end
      end
   end

   // Downstream ready pattern
   initial begin
      t_ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         if (tr_mode == 0)      t_ready = 1'b1;
         else if (tr_mode == 1) t_ready = ~t_ready;
         else                   t_ready = 1'b0;
      end
   end

   // Protocol monitor, sampling on the falling edge
   initial begin
      reset_stats();
      ps_en_prev = 1'b0;
      tv_prev    = 1'b0;
      pd_cyc     = 0;
      cur_t      = 8'h00;
      forever begin
         @(negedge clk);
         if (rst) begin
            ps_en_prev = 1'b0;
            tv_prev    = 1'b0;
         end else begin
            if (ps_en) begin
               ps_en_cnt++;
               if (ps_en_prev) pulse_err++;
            end
            if (ps_done) pd_cyc = cyc;
            if (t_valid && !tv_prev) begin
               t_log.push_back(T);
               cur_t    = T;
               pt_beats = 0;
               if (cyc - pd_cyc != exp_lat) lat_err++;
            end
            if (t_valid && T != cur_t) stab_err++;
            if (t_valid && t_ready) begin
               beat_cnt++;
               pt_beats++;
            end
            if (tv_prev && !t_valid && pt_beats != exp_caps) beat_err++;
            if (sweep_done) done_cnt++;
            ps_en_prev = ps_en;
            tv_prev    = t_valid;
         end
      end
   end

   task automatic do_start(input string tag);
      @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
      chk({tag, "_ps_en"}, {31'd0, ps_en}, 32'd1);
   endtask

   task automatic wait_idle(input string tag, input int budget);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (busy && n < budget);
      chk(tag, {31'd0, busy}, 32'd0);
   endtask

   task automatic wait_done(input string tag, input int budget);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!sweep_done && n < budget);
      chk(tag, {31'd0, sweep_done}, 32'd1);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_ps_en"},      {31'd0, ps_en},      32'd0);
      chk({tag, "_T"},          {24'd0, T},          32'd0);
      chk({tag, "_t_valid"},    {31'd0, t_valid},    32'd0);
      chk({tag, "_busy"},       {31'd0, busy},       32'd0);
      chk({tag, "_sweep_done"}, {31'd0, sweep_done}, 32'd0);
      chk({tag, "_err"},        {31'd0, err},        32'd0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL global_timeout: observed no finish, expected finish");
      $fatal(1);
   end

   initial begin
      int n;
      rst             = 1'b1;
      start           = 1'b0;
      continuous      = 1'b0;
      settle_cycles   = 16'd0;
      captures_per_pt = 16'd0;

      // Reset state
      @(negedge clk);
      check_reset_outputs("rst0");
      #1 rst = 1'b0;

      // Single sweep: settle 3, 2 beats per point
      settle_cycles = 16'd3; captures_per_pt = 16'd2;
      exp_lat = 4; exp_caps = 2; tr_mode = 0; ps_delay = 5;
      @(posedge clk); #1 reset_stats();
      do_start("s1");
      wait_idle("s1_idle", 400);
      chk("s1_ps_en_cnt", ps_en_cnt, 3);
      chk("s1_beats", beat_cnt, 6);
      chk("s1_done_cnt", done_cnt, 1);
      chk("s1_points", t_log.size(), 3);
      chk("s1_T0", {24'd0, tlog_at(0)}, 32'h82);
      chk("s1_T1", {24'd0, tlog_at(1)}, 32'h03);
      chk("s1_T2", {24'd0, tlog_at(2)}, 32'h04);
      chk("s1_latency", lat_err, 0);
      chk("s1_ps_en_width", pulse_err, 0);
      chk("s1_beats_per_pt", beat_err, 0);
      chk("s1_T_hold", {24'd0, T}, 32'h04);
      chk("s1_err", {31'd0, err}, 32'd0);

      // Backpressure: 4 beats per point, ready toggling
      settle_cycles = 16'd3; captures_per_pt = 16'd4;
      exp_lat = 4; exp_caps = 4; tr_mode = 1;
      @(posedge clk); #1 reset_stats();
      do_start("bp");
      wait_idle("bp_idle", 600);
      chk("bp_beats", beat_cnt, 12);
      chk("bp_beats_per_pt", beat_err, 0);
      chk("bp_T_stable", stab_err, 0);
      chk("bp_done_cnt", done_cnt, 1);
      chk("bp_latency", lat_err, 0);

      // Zero settle and zero captures
      settle_cycles = 16'd0; captures_per_pt = 16'd0;
      exp_lat = 1; exp_caps = 1; tr_mode = 0;
      @(posedge clk); #1 reset_stats();
      do_start("z");
      wait_idle("z_idle", 400);
      chk("z_beats", beat_cnt, 3);
      chk("z_latency", lat_err, 0);
      chk("z_beats_per_pt", beat_err, 0);
      chk("z_T0", {24'd0, tlog_at(0)}, 32'h82);

      // Continuous sweeps, then drop continuous during the third sweep
      settle_cycles = 16'd1; captures_per_pt = 16'd1;
      exp_lat = 2; exp_caps = 1; tr_mode = 0; continuous = 1'b1;
      @(posedge clk); #1 reset_stats();
      do_start("c");
      wait_done("c_done1", 400);
      chk("c_done1_T", {24'd0, T}, 32'h04);
      @(negedge clk);
      chk("c_wrap_T", {24'd0, T}, 32'h82);
      chk("c_wrap_ps_en", {31'd0, ps_en}, 32'd1);
      chk("c_wrap_busy", {31'd0, busy}, 32'd1);
      chk("c_wrap_done_low", {31'd0, sweep_done}, 32'd0);
      wait_done("c_done2", 400);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (t_log.size() < 7 && n < 400);
      continuous = 1'b0;
      wait_idle("c_idle", 400);
      chk("c_done_cnt", done_cnt, 3);
      chk("c_ps_en_cnt", ps_en_cnt, 9);
      chk("c_beats", beat_cnt, 9);
      chk("c_T7", {24'd0, tlog_at(6)}, 32'h82);
      chk("c_T_hold", {24'd0, T}, 32'h04);

      // Reset while capturing at T=0x03, then restart
      settle_cycles = 16'd0; captures_per_pt = 16'd2;
      exp_lat = 1; exp_caps = 2; tr_mode = 0;
      @(posedge clk); #1 reset_stats();
      do_start("r");
      n = 0;
      while (!(t_valid && T == 8'h03) && n < 400) begin
         @(negedge clk);
         n++;
      end
      chk("r_reach_T3", {24'd0, T}, 32'h03);
      #1 rst = 1'b1;
      #1;
      check_reset_outputs("r_async");
      @(negedge clk);
      #1 rst = 1'b0;
      @(posedge clk); #1 reset_stats();
      do_start("r2");
      wait_idle("r2_idle", 400);
      chk("r2_points", t_log.size(), 3);
      chk("r2_T0", {24'd0, tlog_at(0)}, 32'h82);
      chk("r2_done_cnt", done_cnt, 1);

      // Withheld ps_done: watchdog behaviour
      settle_cycles = 16'd0; captures_per_pt = 16'd1; ps_hold = 1'b1;
      @(posedge clk); #1 reset_stats();
      do_start("wd");
      repeat (65600) @(negedge clk);
`ifdef ETS_SEQ_PS_TIMEOUT_EN
      chk("wd_err", {31'd0, err}, 32'd1);
      chk("wd_busy", {31'd0, busy}, 32'd0);
`else
      chk("wd_err", {31'd0, err}, 32'd0);
      chk("wd_busy", {31'd0, busy}, 32'd1);
`endif
      chk("wd_t_valid", {31'd0, t_valid}, 32'd0);
      chk("wd_no_beats", beat_cnt, 0);
      ps_hold = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
